dmem_responder: RTL and testbench

Memory-side responder for the core's data-memory port. It accepts one load or store request at a time over a valid/ready request channel. It inserts a configurable number of wait states, then returns read data or a write acknowledge, with an error flag, over a valid/ready response channel. It sits between the core's load/store path and a word-organised on-chip data array. This lets the core be exercised against non-zero memory latency.

---
 rtl/dmem_pkg.sv | 32 +++
 rtl/dmem_word_array.sv | 30 +++
 rtl/dmem_responder.sv | 147 ++++++++++++++
 tb/tb_dmem_responder.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, widths and address checks for the data-memory responder
package dmem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Word offset of a byte address relative to the array base.
  function automatic logic [ADDR_W-1:0] word_offset(
    input logic [ADDR_W-1:0] addr,
    input logic [ADDR_W-1:0] base
  );
    return (addr - base) >> 2;
  endfunction

  // A request is rejected when misaligned, below the base, or past the last word.
  function automatic logic addr_err(
    input logic [ADDR_W-1:0] addr,
    input logic [ADDR_W-1:0] base,
    input int unsigned       depth
  );
    logic [ADDR_W-1:0] off;
    off = word_offset(addr, base);
    return (addr[1:0] != 2'b00) || (addr < base) || (off >= ADDR_W'(depth));
  endfunction

endpackage

// File: rtl/dmem_word_array.sv
// rtl/dmem_word_array.sv - word-organised storage with byte-enabled write and combinational read
module dmem_word_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // Contents are deliberately not reset; software sees whatever was last stored.
  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Write only the enabled byte lanes of the indexed word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding load/store responder with configurable wait states
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int              DEPTH_WORDS = 256,
  parameter int              WAIT_CYCLES = 1,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t state, state_next;

  logic [3:0]        wait_cnt;
  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [3:0]        lat_be;
  logic              lat_err;

  logic              accept;
  logic              commit;
  logic              req_err;
  logic              use_req;

  logic              src_write;
  logic              src_err;
  logic [ADDR_W-1:0] src_addr;
  logic [DATA_W-1:0] src_wdata;
  logic [3:0]        src_be;
  logic [IDX_W-1:0]  src_idx;

  logic              arr_we;
  logic [DATA_W-1:0] arr_rdata;

  assign req_err = addr_err(req_addr, BASE_ADDR, $unsigned(DEPTH_WORDS));

  // With zero wait states the commit happens on the accept edge itself, so the
  // array must see the live request; otherwise it sees the latched copy.
  assign use_req   = (state == IDLE);
  assign src_write = use_req ? req_write : lat_write;
  assign src_addr  = use_req ? req_addr  : lat_addr;
  assign src_wdata = use_req ? req_wdata : lat_wdata;
  assign src_be    = use_req ? req_be    : lat_be;
  assign src_err   = use_req ? req_err   : lat_err;

  // Index truncation is safe because out-of-range addresses never reach the array.
  assign src_idx = IDX_W'(word_offset(src_addr, BASE_ADDR));

  // Reset gating keeps an uncommitted store out of the (unreset) array.
  assign arr_we = commit && src_write && !src_err && !reset;

  // State register; reset drops any in-flight transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state, handshake outputs and accept/commit strobes.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
            commit     = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_next = RESP;
          commit     = 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture, wait countdown and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt  <= 4'd0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= 4'd0;
      lat_err   <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
        lat_err   <= req_err;
        wait_cnt  <= WAIT_LOAD;
      end else if (state == WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (commit) begin
        rsp_err   <= src_err;
        rsp_rdata <= (!src_write && !src_err) ? arr_rdata : '0;
      end
    end
  end

  dmem_word_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .be    (src_be),
    .idx   (src_idx),
    .wdata (src_wdata),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench over four wait-state builds
module tb_dmem_responder;

  localparam logic [31:0] TB_BASE  = 32'h0;
  localparam int          TB_DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset_v   [4];
  logic        req_valid [4];
  logic        req_ready [4];
  logic        req_write [4];
  logic [31:0] req_addr  [4];
  logic [31:0] req_wdata [4];
  logic [3:0]  req_be    [4];
  logic        rsp_valid [4];
  logic        rsp_ready [4];
  logic [31:0] rsp_rdata [4];
  logic        rsp_err   [4];

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] mem_m [4][TB_DEPTH];

  always #5 clk = ~clk;

  // Instance g is built with g wait states.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS (TB_DEPTH),
      .WAIT_CYCLES (g),
      .BASE_ADDR   (TB_BASE)
    ) u_dut (
      .clk       (clk),
      .reset     (reset_v[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_write (req_write[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_be    (req_be[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  // Reference: errors from address arithmetic, memory as a plain word array.
  function automatic void model_apply(input int w, input bit wr, input logic [31:0] addr,
                                      input logic [31:0] wdata, input logic [3:0] be,
                                      output logic [31:0] rd, output logic er);
    int unsigned off;
    er = (addr % 4 != 0) || (addr < TB_BASE) || ((addr - TB_BASE) / 4 >= TB_DEPTH);
    rd = 32'h0;
    if (!er) begin
      off = (addr - TB_BASE) / 4;
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mem_m[w][off][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        rd = mem_m[w][off];
      end
    end
  endfunction

  // One full request/response; checks stability while stalled and IDLE afterwards.
  task automatic txn(input int w, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int stall, input bit intrude,
                     output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    req_valid[w] = 1'b1; req_write[w] = wr; req_addr[w] = addr;
    req_wdata[w] = wdata; req_be[w] = be; rsp_ready[w] = 1'b0;
    n = 0;
    while (req_ready[w] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    vectors++;
    if (n >= 50) begin miscompares++; $display("FAIL accept_timeout inst=%0d waited=%0d", w, n); end
    @(negedge clk);
    req_valid[w] = 1'b0;
    lat = 1;
    while (rsp_valid[w] !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
    vectors++;
    if (lat >= 50) begin miscompares++; $display("FAIL rsp_timeout inst=%0d waited=%0d", w, lat); end
    rd = rsp_rdata[w];
    er = rsp_err[w];
    for (int s = 0; s < stall; s++) begin
      if (intrude && s == 0) begin
        req_valid[w] = 1'b1; req_write[w] = 1'b1; req_addr[w] = 32'h14;
        req_wdata[w] = ~mem_m[w][5]; req_be[w] = 4'hF;
      end
      @(negedge clk);
      vectors++;
      if ({rsp_valid[w], req_ready[w], rsp_err[w], rsp_rdata[w]} !== {1'b1, 1'b0, er, rd}) begin
        miscompares++;
        $display("FAIL stall_hold inst=%0d cyc=%0d got v=%b rdy=%b err=%b rd=%h want v=1 rdy=0 err=%b rd=%h",
                 w, s, rsp_valid[w], req_ready[w], rsp_err[w], rsp_rdata[w], er, rd);
      end
    end
    req_valid[w] = 1'b0;
    rsp_ready[w] = 1'b1;
    @(negedge clk);
    rsp_ready[w] = 1'b0;
    vectors++;
    if (req_ready[w] !== 1'b1 || rsp_valid[w] !== 1'b0) begin
      miscompares++;
      $display("FAIL post_handshake inst=%0d got rdy=%b v=%b want rdy=1 v=0", w, req_ready[w], rsp_valid[w]);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int w = 0; w < 4; w++) begin
      vectors++;
      if ({req_ready[w], rsp_valid[w], rsp_err[w], rsp_rdata[w]} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
        miscompares++;
        $display("FAIL reset_state inst=%0d got rdy=%b v=%b err=%b rd=%h want 1 0 0 0",
                 w, req_ready[w], rsp_valid[w], rsp_err[w], rsp_rdata[w]);
      end
      reset_v[w] = 1'b0;
    end
    @(negedge clk);
    for (int w = 0; w < 4; w++) begin
      vectors++;
      if (req_ready[w] !== 1'b1 || rsp_valid[w] !== 1'b0) begin
        miscompares++;
        $display("FAIL after_reset inst=%0d got rdy=%b v=%b want 1 0", w, req_ready[w], rsp_valid[w]);
      end
    end
  endtask

  task automatic test_prefill(input int w);
    logic [31:0] rd, erd, d; logic er, eer; int lat;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      txn(w, 1'b1, 32'(i * 4), d, 4'hF, 0, 1'b0, rd, er, lat);
      model_apply(w, 1'b1, 32'(i * 4), d, 4'hF, erd, eer);
      vectors++;
      if (rd !== erd || er !== eer) begin
        miscompares++;
        $display("FAIL prefill inst=%0d word=%0d got rd=%h err=%b want rd=%h err=%b", w, i, rd, er, erd, eer);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] rd, erd; logic er, eer; int lat;
    txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, rd, er, lat);
    model_apply(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, erd, eer);
    vectors++;
    if (lat != 2 || er !== 1'b0 || rd !== 32'h0) begin
      miscompares++;
      $display("FAIL basic_store got lat=%0d err=%b rd=%h want lat=2 err=0 rd=0", lat, er, rd);
    end
    txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
    vectors++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      miscompares++; $display("FAIL basic_load got rd=%h err=%b want deadbeef 0", rd, er);
    end
    txn(1, 1'b1, 32'h10, 32'h11223344, 4'b0101, 0, 1'b0, rd, er, lat);
    model_apply(1, 1'b1, 32'h10, 32'h11223344, 4'b0101, erd, eer);
    txn(1, 1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0, rd, er, lat);
    vectors++;
    if (rd !== 32'hDE22BE44 || er !== 1'b0) begin
      miscompares++; $display("FAIL partial_store got rd=%h err=%b want de22be44 0", rd, er);
    end
    txn(1, 1'b0, 32'h13, 32'h0, 4'hF, 0, 1'b0, rd, er, lat);
    vectors++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      miscompares++; $display("FAIL misaligned_load got rd=%h err=%b want 0 1", rd, er);
    end
    txn(1, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 0, 1'b0, rd, er, lat);
    vectors++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      miscompares++; $display("FAIL range_store got rd=%h err=%b want 0 1", rd, er);
    end
    txn(1, 1'b0, 32'h0, 32'h0, 4'hF, 0, 1'b0, rd, er, lat);
    model_apply(1, 1'b0, 32'h0, 32'h0, 4'hF, erd, eer);
    vectors++;
    if (rd !== erd || er !== 1'b0) begin
      miscompares++; $display("FAIL range_no_write got rd=%h want %h", rd, erd);
    end
    txn(1, 1'b1, 32'h8, 32'h0BAD0BAD, 4'h0, 0, 1'b0, rd, er, lat);
    vectors++;
    if (er !== 1'b0) begin miscompares++; $display("FAIL zero_be_err got %b want 0", er); end
    txn(1, 1'b0, 32'h8, 32'h0, 4'hF, 0, 1'b0, rd, er, lat);
    model_apply(1, 1'b0, 32'h8, 32'h0, 4'hF, erd, eer);
    vectors++;
    if (rd !== erd) begin miscompares++; $display("FAIL zero_be_data got %h want %h", rd, erd); end
  endtask

  task automatic test_stall();
    logic [31:0] rd, erd; logic er, eer; int lat;
    txn(1, 1'b1, 32'h18, 32'hCAFEF00D, 4'hF, 0, 1'b0, rd, er, lat);
    model_apply(1, 1'b1, 32'h18, 32'hCAFEF00D, 4'hF, erd, eer);
    txn(1, 1'b0, 32'h18, 32'h0, 4'hF, 5, 1'b1, rd, er, lat);
    vectors++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
      miscompares++; $display("FAIL stall_load got rd=%h err=%b want cafef00d 0", rd, er);
    end
    txn(1, 1'b0, 32'h14, 32'h0, 4'hF, 0, 1'b0, rd, er, lat);
    model_apply(1, 1'b0, 32'h14, 32'h0, 4'hF, erd, eer);
    vectors++;
    if (rd !== erd) begin miscompares++; $display("FAIL intrude_ignored got %h want %h", rd, erd); end
  endtask

  task automatic test_latency();
    logic [31:0] rd; logic er; int lat;
    for (int w = 0; w < 4; w++) begin
      txn(w, 1'b0, 32'h4, 32'h0, 4'hF, 0, 1'b0, rd, er, lat);
      vectors++;
      if (lat != w + 1) begin
        miscompares++; $display("FAIL latency inst=%0d got %0d want %0d", w, lat, w + 1);
      end
    end
  endtask

  task automatic test_back_to_back(input int w);
    int acc [3];
    int k = 0, nrsp = 0, cyc = 0;
    logic [31:0] q [$];
    logic [31:0] erd; logic eer;
    @(negedge clk);
    rsp_ready[w] = 1'b1; req_valid[w] = 1'b1; req_write[w] = 1'b0;
    req_addr[w] = 32'h20; req_be[w] = 4'hF; req_wdata[w] = 32'h0;
    while (nrsp < 3 && cyc < 100) begin
      if (rsp_valid[w] === 1'b1) begin
        vectors++;
        if (q.size() == 0 || rsp_rdata[w] !== q[0]) begin
          miscompares++;
          $display("FAIL b2b_data inst=%0d got %h want %h", w, rsp_rdata[w], (q.size() != 0) ? q[0] : 32'hx);
        end
        if (q.size() != 0) void'(q.pop_front());
        nrsp++;
      end
      if (req_valid[w] === 1'b1 && req_ready[w] === 1'b1) begin
        acc[k] = cyc;
        model_apply(w, 1'b0, req_addr[w], 32'h0, 4'hF, erd, eer);
        q.push_back(erd);
        k++;
      end
      @(negedge clk);
      cyc++;
      if (k < 3) req_addr[w] = 32'h20 + 32'(4 * k);
      else       req_valid[w] = 1'b0;
    end
    req_valid[w] = 1'b0;
    rsp_ready[w] = 1'b0;
    vectors++;
    if (nrsp != 3 || k != 3) begin
      miscompares++; $display("FAIL b2b_count inst=%0d got acc=%0d rsp=%0d want 3 3", w, k, nrsp);
    end else begin
      for (int i = 1; i < 3; i++) begin
        vectors++;
        if (acc[i] - acc[i-1] != w + 2) begin
          miscompares++;
          $display("FAIL b2b_spacing inst=%0d got %0d want %0d", w, acc[i] - acc[i-1], w + 2);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd; logic er, eer; int lat, n;
    txn(2, 1'b0, 32'h0, 32'h0, 4'hF, 0, 1'b0, rd, er, lat);
    @(negedge clk);
    req_valid[2] = 1'b1; req_write[2] = 1'b1; req_addr[2] = 32'h20;
    req_wdata[2] = 32'h55AA55AA; req_be[2] = 4'hF;
    vectors++;
    if (req_ready[2] !== 1'b1) begin miscompares++; $display("FAIL mid_ready got %b want 1", req_ready[2]); end
    @(negedge clk);
    req_valid[2] = 1'b0;
    reset_v[2] = 1'b1;
    #1;
    vectors++;
    if ({req_ready[2], rsp_valid[2], rsp_err[2], rsp_rdata[2]} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_in_wait got rdy=%b v=%b err=%b rd=%h want 1 0 0 0",
               req_ready[2], rsp_valid[2], rsp_err[2], rsp_rdata[2]);
    end
    @(negedge clk);
    reset_v[2] = 1'b0;
    txn(2, 1'b0, 32'h20, 32'h0, 4'hF, 0, 1'b0, rd, er, lat);
    model_apply(2, 1'b0, 32'h20, 32'h0, 4'hF, erd, eer);
    vectors++;
    if (rd !== erd) begin miscompares++; $display("FAIL dropped_store got %h want %h", rd, erd); end
    @(negedge clk);
    req_valid[2] = 1'b1; req_write[2] = 1'b1; req_addr[2] = 32'h24;
    req_wdata[2] = 32'h12345678; req_be[2] = 4'hF;
    @(negedge clk);
    req_valid[2] = 1'b0;
    n = 0;
    while (rsp_valid[2] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    vectors++;
    if (n >= 20) begin miscompares++; $display("FAIL commit_timeout waited=%0d", n); end
    model_apply(2, 1'b1, 32'h24, 32'h12345678, 4'hF, erd, eer);
    reset_v[2] = 1'b1;
    @(negedge clk);
    reset_v[2] = 1'b0;
    txn(2, 1'b0, 32'h24, 32'h0, 4'hF, 0, 1'b0, rd, er, lat);
    vectors++;
    if (rd !== 32'h12345678) begin miscompares++; $display("FAIL committed_kept got %h want 12345678", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, addr, d; logic er, eer; int lat, sel; bit wr; logic [3:0] be;
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < 30; i++) begin
        wr  = 1'($urandom_range(0, 1));
        sel = $urandom_range(0, 9);
        d   = $urandom;
        be  = 4'($urandom);
        if (sel < 7)       addr = 32'(4 * $urandom_range(0, 15));
        else if (sel == 7) addr = 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
        else if (sel == 8) addr = 32'h400 + 32'(4 * $urandom_range(0, 63));
        else               addr = $urandom | 32'h0000_0400;
        txn(w, wr, addr, d, be, $urandom_range(0, 2), 1'b0, rd, er, lat);
        model_apply(w, wr, addr, d, be, erd, eer);
        vectors++;
        if (rd !== erd || er !== eer || lat != w + 1) begin
          miscompares++;
          $display("FAIL random inst=%0d wr=%0d addr=%h got rd=%h err=%b lat=%0d want rd=%h err=%b lat=%0d",
                   w, wr, addr, rd, er, lat, erd, eer, w + 1);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      reset_v[i] = 1'b1; req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = 32'h0;
      req_wdata[i] = 32'h0; req_be[i] = 4'h0; rsp_ready[i] = 1'b0;
    end
    test_reset();
    for (int w = 0; w < 4; w++) test_prefill(w);
    test_basic();
    test_stall();
    test_latency();
    test_back_to_back(0);
    test_back_to_back(1);
    test_back_to_back(3);
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
